// File: rtl/sec_mon_pkg.sv
// Shared definitions for the security monitor and its violation handler.
//
// Contents:
//   vh_state_e        - violation handler FSM state encoding
//   CAUSE_*_BIT       - bit positions inside the 3-bit viol_cause record
//   *_MIN / *_MAX     - legal ranges for the handler parameters
//   sat_inc8()        - 8-bit saturating increment used by the violation counter
package sec_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_COOL = 2'd2,
        ST_LOCK = 2'd3
    } vh_state_e;

    localparam int CAUSE_W        = 3;
    localparam int CAUSE_DATA_BIT = 0;
    localparam int CAUSE_CODE_BIT = 1;
    localparam int CAUSE_WR_BIT   = 2;

    localparam int TIMER_W = 8;
    localparam int COUNT_W = 8;

    localparam int RST_HOLD_MIN = 1;
    localparam int RST_HOLD_MAX = 255;
    localparam int COOLDOWN_MIN = 0;
    localparam int COOLDOWN_MAX = 255;
    localparam int MAX_VIOL_MIN = 1;
    localparam int MAX_VIOL_MAX = 255;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [COUNT_W-1:0] sat_inc8(input logic [COUNT_W-1:0] v);
        logic [COUNT_W-1:0] r;
        if (v == {COUNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/violation_handler_hold_timer.sv
// hold_timer: 8-bit loadable down-counter used for both the CPU reset pulse
// width and the post-pulse cooldown window.
//
// Ports:
//   clk, rst   - clock and asynchronous active-high reset (counter -> 0)
//   load       - load load_val this cycle (has priority over en)
//   load_val   - value to load
//   en         - decrement by one when the counter is non-zero
//   value      - current counter value
//   zero       - counter value is zero
module hold_timer
    import sec_mon_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic [TIMER_W-1:0] value,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(TIMER_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/violation_handler.sv
// violation_handler: turns the access monitor's violation level into a timed
// CPU reset pulse, records what caused it, counts accepted violations and
// latches a permanent-reset lockout once the count reaches MAX_VIOL.
//
// Parameters:
//   RST_HOLD  - CPU reset pulse width in cycles (1..255)
//   COOLDOWN  - cycles after the pulse during which violations are ignored (0..255)
//   MAX_VIOL  - accepted-violation count that triggers lockout (1..255)
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   viol                 - violation level from the access monitor
//   pc                   - CPU program counter
//   data_en/code_en/code_wr, data_addr/code_addr - access qualifiers/addresses
//   clr_status           - software acknowledge, clears viol_valid only
//   cpu_rst_req          - registered CPU reset request
//   viol_valid           - a capture record is present
//   viol_pc, viol_addr   - captured pc and faulting address
//   viol_cause           - {code write, code fetch, data access}
//   viol_count           - accepted violations, saturating at 255
//   lockout              - permanent-reset state flag
//
// Every output is a flop; cpu_rst_req must be routed to the CPU reset tree
// downstream and never back into rst.
module violation_handler
    import sec_mon_pkg::*;
#(
    parameter int RST_HOLD = 8,
    parameter int COOLDOWN = 4,
    parameter int MAX_VIOL = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               viol,
    input  logic [15:0]        pc,
    input  logic               data_en,
    input  logic               code_en,
    input  logic               code_wr,
    input  logic [15:0]        data_addr,
    input  logic [15:0]        code_addr,
    input  logic               clr_status,
    output logic               cpu_rst_req,
    output logic               viol_valid,
    output logic [15:0]        viol_pc,
    output logic [15:0]        viol_addr,
    output logic [CAUSE_W-1:0] viol_cause,
    output logic [COUNT_W-1:0] viol_count,
    output logic               lockout
);

    // Elaboration-time parameter range checks.
    if ((RST_HOLD < RST_HOLD_MIN) || (RST_HOLD > RST_HOLD_MAX)) begin : g_bad_rst_hold
        $error("violation_handler: RST_HOLD out of range 1..255");
    end
    if ((COOLDOWN < COOLDOWN_MIN) || (COOLDOWN > COOLDOWN_MAX)) begin : g_bad_cooldown
        $error("violation_handler: COOLDOWN out of range 0..255");
    end
    if ((MAX_VIOL < MAX_VIOL_MIN) || (MAX_VIOL > MAX_VIOL_MAX)) begin : g_bad_max_viol
        $error("violation_handler: MAX_VIOL out of range 1..255");
    end

    // The timer is loaded with N-1 and the phase ends on the cycle it reads
    // zero, so a phase lasts exactly N cycles.
    localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(RST_HOLD - 1);
    localparam logic [TIMER_W-1:0] COOL_LOAD  = (COOLDOWN > 0) ? TIMER_W'(COOLDOWN - 1) : '0;
    localparam logic               COOL_EN    = (COOLDOWN > 0);
    localparam logic [COUNT_W-1:0] MAX_VIOL_C = COUNT_W'(MAX_VIOL);

    vh_state_e          state_q, state_d;
    logic               cpu_rst_req_q, cpu_rst_req_d;
    logic               viol_valid_q, viol_valid_d;
    logic [15:0]        viol_pc_q, viol_pc_d;
    logic [15:0]        viol_addr_q, viol_addr_d;
    logic [CAUSE_W-1:0] viol_cause_q, viol_cause_d;
    logic [COUNT_W-1:0] viol_count_q, viol_count_d;
    logic               lockout_q, lockout_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_en;
    logic               timer_zero;
    // Counter value is only observed through the zero flag here.
    logic [TIMER_W-1:0] timer_value_unused;

    hold_timer u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (timer_en),
        .value    (timer_value_unused),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d        = state_q;
        cpu_rst_req_d  = cpu_rst_req_q;
        viol_valid_d   = viol_valid_q;
        viol_pc_d      = viol_pc_q;
        viol_addr_d    = viol_addr_q;
        viol_cause_d   = viol_cause_q;
        viol_count_d   = viol_count_q;
        lockout_d      = lockout_q;
        timer_load     = 1'b0;
        timer_load_val = HOLD_LOAD;
        timer_en       = 1'b0;

        // Acknowledge first so that an acceptance in the same cycle overrides it.
        if (clr_status) begin
            viol_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (viol) begin
                    viol_pc_d                    = pc;
                    viol_addr_d                  = data_en ? data_addr : code_addr;
                    viol_cause_d                 = '0;
                    viol_cause_d[CAUSE_DATA_BIT] = data_en;
                    viol_cause_d[CAUSE_CODE_BIT] = code_en;
                    viol_cause_d[CAUSE_WR_BIT]   = code_wr;
                    viol_valid_d                 = 1'b1;
                    viol_count_d                 = sat_inc8(viol_count_q);
                    cpu_rst_req_d                = 1'b1;
                    timer_load                   = 1'b1;
                    timer_load_val               = HOLD_LOAD;
                    state_d                      = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (timer_zero) begin
                    // viol_count_q already includes the violation that opened this pulse.
                    if (viol_count_q >= MAX_VIOL_C) begin
                        state_d   = ST_LOCK;
                        lockout_d = 1'b1;
                    end else if (COOL_EN) begin
                        state_d        = ST_COOL;
                        cpu_rst_req_d  = 1'b0;
                        timer_load     = 1'b1;
                        timer_load_val = COOL_LOAD;
                    end else begin
                        state_d       = ST_IDLE;
                        cpu_rst_req_d = 1'b0;
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end

            ST_COOL: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end

            ST_LOCK: begin
                cpu_rst_req_d = 1'b1;
                lockout_d     = 1'b1;
            end

            default: begin
                state_d       = ST_IDLE;
                cpu_rst_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cpu_rst_req_q <= 1'b0;
            viol_valid_q  <= 1'b0;
            viol_pc_q     <= '0;
            viol_addr_q   <= '0;
            viol_cause_q  <= '0;
            viol_count_q  <= '0;
            lockout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpu_rst_req_q <= cpu_rst_req_d;
            viol_valid_q  <= viol_valid_d;
            viol_pc_q     <= viol_pc_d;
            viol_addr_q   <= viol_addr_d;
            viol_cause_q  <= viol_cause_d;
            viol_count_q  <= viol_count_d;
            lockout_q     <= lockout_d;
        end
    end

    assign cpu_rst_req = cpu_rst_req_q;
    assign viol_valid  = viol_valid_q;
    assign viol_pc     = viol_pc_q;
    assign viol_addr   = viol_addr_q;
    assign viol_cause  = viol_cause_q;
    assign viol_count  = viol_count_q;
    assign lockout     = lockout_q;

endmodule

// File: tb/tb_violation_handler.sv
// Bench for violation_handler. Three instances share one stimulus stream:
//   u0: defaults (RST_HOLD=8, COOLDOWN=4, MAX_VIOL=16)
//   u1: MAX_VIOL=2 (lockout scenario)
//   u2: RST_HOLD=1, COOLDOWN=0, MAX_VIOL=255 (saturation scenario)
// A timeline model predicts each instance's outputs: an acceptance at edge n
// drives the reset pulse over edges n..n+RST_HOLD-1 and blocks new acceptances
// until edge n+RST_HOLD+COOLDOWN+1.
module tb_violation_handler;

    localparam int INF = 1 << 30;
    localparam int RH [3] = '{8, 8, 1};
    localparam int CD [3] = '{4, 4, 0};
    localparam int MV [3] = '{16, 2, 255};

    logic        clk;
    logic        rst;
    logic        viol;
    logic [15:0] pc;
    logic        data_en, code_en, code_wr;
    logic [15:0] data_addr, code_addr;
    logic        clr_status;

    logic [2:0]  cpu_rst_req_w;
    logic [2:0]  viol_valid_w;
    logic [2:0]  lockout_w;
    logic [15:0] viol_pc_w    [3];
    logic [15:0] viol_addr_w  [3];
    logic [2:0]  viol_cause_w [3];
    logic [7:0]  viol_count_w [3];

    int n_assert = 0;
    int n_fail   = 0;

    violation_handler #(.RST_HOLD(8), .COOLDOWN(4), .MAX_VIOL(16)) u0 (
        .clk(clk), .rst(rst), .viol(viol), .pc(pc),
        .data_en(data_en), .code_en(code_en), .code_wr(code_wr),
        .data_addr(data_addr), .code_addr(code_addr), .clr_status(clr_status),
        .cpu_rst_req(cpu_rst_req_w[0]), .viol_valid(viol_valid_w[0]),
        .viol_pc(viol_pc_w[0]), .viol_addr(viol_addr_w[0]),
        .viol_cause(viol_cause_w[0]), .viol_count(viol_count_w[0]),
        .lockout(lockout_w[0])
    );

    violation_handler #(.RST_HOLD(8), .COOLDOWN(4), .MAX_VIOL(2)) u1 (
        .clk(clk), .rst(rst), .viol(viol), .pc(pc),
        .data_en(data_en), .code_en(code_en), .code_wr(code_wr),
        .data_addr(data_addr), .code_addr(code_addr), .clr_status(clr_status),
        .cpu_rst_req(cpu_rst_req_w[1]), .viol_valid(viol_valid_w[1]),
        .viol_pc(viol_pc_w[1]), .viol_addr(viol_addr_w[1]),
        .viol_cause(viol_cause_w[1]), .viol_count(viol_count_w[1]),
        .lockout(lockout_w[1])
    );

    violation_handler #(.RST_HOLD(1), .COOLDOWN(0), .MAX_VIOL(255)) u2 (
        .clk(clk), .rst(rst), .viol(viol), .pc(pc),
        .data_en(data_en), .code_en(code_en), .code_wr(code_wr),
        .data_addr(data_addr), .code_addr(code_addr), .clr_status(clr_status),
        .cpu_rst_req(cpu_rst_req_w[2]), .viol_valid(viol_valid_w[2]),
        .viol_pc(viol_pc_w[2]), .viol_addr(viol_addr_w[2]),
        .viol_cause(viol_cause_w[2]), .viol_count(viol_count_w[2]),
        .lockout(lockout_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- timeline model ----------------
    int          m_n;
    int          m_cnt       [3];
    int          m_valid     [3];
    int          m_pc        [3];
    int          m_addr      [3];
    int          m_cause     [3];
    int          m_rst_start [3];
    int          m_rst_end   [3];
    int          m_lock_at   [3];
    int          m_next_ok   [3];

    task automatic model_reset();
        m_n = -1;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_valid[k] = 0; m_pc[k] = 0; m_addr[k] = 0; m_cause[k] = 0;
            m_rst_start[k] = INF; m_rst_end[k] = INF; m_lock_at[k] = INF; m_next_ok[k] = 0;
        end
    endtask

    initial model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            m_n = m_n + 1;
            for (int k = 0; k < 3; k++) begin
                if (viol && (m_n >= m_next_ok[k])) begin
                    m_pc[k]    = int'(pc);
                    m_addr[k]  = data_en ? int'(data_addr) : int'(code_addr);
                    m_cause[k] = int'(code_wr) * 4 + int'(code_en) * 2 + int'(data_en);
                    m_valid[k] = 1;
                    if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
                    m_rst_start[k] = m_n;
                    m_rst_end[k]   = m_n + RH[k];
                    if (m_cnt[k] >= MV[k]) begin
                        m_lock_at[k] = m_n + RH[k];
                        m_next_ok[k] = INF;
                    end else begin
                        m_next_ok[k] = m_n + RH[k] + CD[k] + 1;
                    end
                end else if (clr_status) begin
                    m_valid[k] = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic exp_rst;
            exp_rst = ((m_n >= m_rst_start[k]) && (m_n < m_rst_end[k])) || (m_n >= m_lock_at[k]);
            check($sformatf("u%0d.cpu_rst_req", k), 32'(cpu_rst_req_w[k]), 32'(exp_rst));
            check($sformatf("u%0d.lockout", k), 32'(lockout_w[k]), 32'(m_n >= m_lock_at[k]));
            check($sformatf("u%0d.viol_valid", k), 32'(viol_valid_w[k]), 32'(m_valid[k]));
            check($sformatf("u%0d.viol_count", k), 32'(viol_count_w[k]), 32'(m_cnt[k]));
            check($sformatf("u%0d.viol_pc", k), 32'(viol_pc_w[k]), 32'(m_pc[k]));
            check($sformatf("u%0d.viol_addr", k), 32'(viol_addr_w[k]), 32'(m_addr[k]));
            check($sformatf("u%0d.viol_cause", k), 32'(viol_cause_w[k]), 32'(m_cause[k]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic clear_inputs();
        viol = 1'b0; pc = '0; data_en = 1'b0; code_en = 1'b0; code_wr = 1'b0;
        data_addr = '0; code_addr = '0; clr_status = 1'b0;
    endtask

    task automatic do_reset();
        step(1);
        rst = 1'b1;
        clear_inputs();
        step(2);
        rst = 1'b0;
    endtask

    int hi;

    initial begin
        rst = 1'b1;
        clear_inputs();
        step(3);
        check("reset_cpu_rst_req", 32'(cpu_rst_req_w[0]), 32'd0);
        check("reset_viol_count",  32'(viol_count_w[0]),  32'd0);
        check("reset_viol_valid",  32'(viol_valid_w[0]),  32'd0);
        check("reset_lockout",     32'(lockout_w[0]),     32'd0);
        rst = 1'b0;

        // Basic data violation
        data_en = 1'b1; data_addr = 16'h0600; code_addr = 16'h0777; pc = 16'h1234; viol = 1'b1;
        step(1);
        viol = 1'b0;
        check("basic_viol_addr",  32'(viol_addr_w[0]),  32'h0600);
        check("basic_viol_cause", 32'(viol_cause_w[0]), 32'b001);
        check("basic_viol_pc",    32'(viol_pc_w[0]),    32'h1234);
        check("basic_viol_count", 32'(viol_count_w[0]), 32'd1);
        check("basic_rst_rise",   32'(cpu_rst_req_w[0]), 32'd1);
        hi = int'(cpu_rst_req_w[0]);
        for (int i = 0; i < 15; i++) begin
            step(1);
            hi += int'(cpu_rst_req_w[0]);
        end
        check("basic_rst_width", 32'(hi), 32'd8);

        // Violation during HOLD is ignored
        do_reset();
        data_en = 1'b0; code_en = 1'b1; code_wr = 1'b1;
        code_addr = 16'hA010; data_addr = 16'h1111; pc = 16'hBEEF; viol = 1'b1;
        step(1);
        viol = 1'b0;
        step(2);
        pc = 16'h5555; code_addr = 16'h7777; data_en = 1'b1; viol = 1'b1;
        step(1);
        viol = 1'b0;
        check("hold_ign_count", 32'(viol_count_w[0]), 32'd1);
        check("hold_ign_cause", 32'(viol_cause_w[0]), 32'b110);
        check("hold_ign_addr",  32'(viol_addr_w[0]),  32'hA010);
        check("hold_ign_pc",    32'(viol_pc_w[0]),    32'hBEEF);
        step(12);

        // Acknowledge vs capture
        clr_status = 1'b1;
        step(1);
        clr_status = 1'b0;
        check("clr_valid", 32'(viol_valid_w[0]), 32'd0);
        check("clr_count", 32'(viol_count_w[0]), 32'd1);
        check("clr_addr",  32'(viol_addr_w[0]),  32'hA010);
        clr_status = 1'b1; viol = 1'b1; data_en = 1'b1; code_en = 1'b0; code_wr = 1'b0;
        data_addr = 16'h0ABC;
        step(1);
        clr_status = 1'b0; viol = 1'b0;
        check("clr_acc_valid", 32'(viol_valid_w[0]), 32'd1);
        check("clr_acc_count", 32'(viol_count_w[0]), 32'd2);
        check("clr_acc_addr",  32'(viol_addr_w[0]),  32'h0ABC);
        check("clr_acc_cause", 32'(viol_cause_w[0]), 32'b001);
        step(14);

        // Violation held high through cooldown re-accepts on first IDLE cycle
        do_reset();
        data_en = 1'b1; data_addr = 16'h0100; viol = 1'b1;
        step(30);
        viol = 1'b0;
        check("held_count_u0", 32'(viol_count_w[0]), 32'd3);
        check("held_count_u2", 32'(viol_count_w[2]), 32'd15);
        step(14);

        // Asynchronous reset mid-HOLD
        do_reset();
        data_en = 1'b1; data_addr = 16'h0200; viol = 1'b1;
        step(1);
        viol = 1'b0;
        step(3);
        check("midhold_rst_before", 32'(cpu_rst_req_w[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("midhold_rst_req",   32'(cpu_rst_req_w[0]), 32'd0);
        check("midhold_rst_count", 32'(viol_count_w[0]),  32'd0);
        check("midhold_rst_valid", 32'(viol_valid_w[0]),  32'd0);
        step(1);
        rst = 1'b0;

        // Lockout with MAX_VIOL=2 (u1)
        do_reset();
        data_en = 1'b1; data_addr = 16'h0300; viol = 1'b1;
        step(1);
        viol = 1'b0;
        step(19);
        viol = 1'b1;
        step(1);
        viol = 1'b0;
        step(10);
        check("lock_flag",   32'(lockout_w[1]),     32'd1);
        check("lock_rstreq", 32'(cpu_rst_req_w[1]), 32'd1);
        step(110);
        check("lock_hold_flag",   32'(lockout_w[1]),     32'd1);
        check("lock_hold_rstreq", 32'(cpu_rst_req_w[1]), 32'd1);
        check("lock_hold_count",  32'(viol_count_w[1]),  32'd2);

        // Saturation (u2), after reset clears the lock
        do_reset();
        check("unlock_flag",   32'(lockout_w[1]),     32'd0);
        check("unlock_rstreq", 32'(cpu_rst_req_w[1]), 32'd0);
        data_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            data_addr = 16'(i);
            viol = 1'b1;
            step(1);
            viol = 1'b0;
            step(2);
        end
        check("sat_count_u2",   32'(viol_count_w[2]),  32'd255);
        check("sat_lockout_u2", 32'(lockout_w[2]),     32'd1);
        check("sat_rstreq_u2",  32'(cpu_rst_req_w[2]), 32'd1);
        check("sat_addr_u2",    32'(viol_addr_w[2]),   32'd254);
        check("sat_count_u0",   32'(viol_count_w[0]),  32'd16);
        check("sat_lockout_u0", 32'(lockout_w[0]),     32'd1);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
